// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared op codes, flag indices and FSM state type for the ALU arbiter
package alu_ctrl_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_2   = 2'b10;
    localparam logic [1:0] OP_3   = 2'b11;

    localparam int FLG_OVF = 4;
    localparam int FLG_PAR = 3;
    localparam int FLG_GT  = 2;
    localparam int FLG_EQ  = 1;
    localparam int FLG_LT  = 0;
    localparam int FLAGW   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } alu_arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set bit at or after last+1, wrapping
module rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          any,
    output logic [IW-1:0] idx
);

    // Walk from the lowest-priority slot (last itself) up to last+1 so the
    // nearest candidate after last overwrites the earlier ones.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(last) + k) % N]) begin
                any = 1'b1;
                idx = IW'((int'(last) + k) % N);
            end
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - round-robin sharing of one combinational ALU among NREQ requesters
module alu_req_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter  int NREQ   = 4,
    parameter  int DW     = 8,
    parameter  int SETTLE = 1,
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*DW-1:0]   req_a,
    input  logic [NREQ*DW-1:0]   req_b,
    input  logic [NREQ*2-1:0]    req_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [DW-1:0]        rsp_y,
    output logic [FLAGW-1:0]     rsp_flags,
    output logic [DW-1:0]        alu_a,
    output logic [DW-1:0]        alu_b,
    output logic [1:0]           alu_op,
    input  logic [DW-1:0]        alu_y,
    input  logic [FLAGW-1:0]     alu_flags,
    output logic                 busy
);

    alu_arb_state_t state;
    logic [3:0]     cnt;
    logic [IDW-1:0] last_grant;
    logic           pick_any;
    logic [IDW-1:0] pick_idx;

    rr_pick #(.N(NREQ)) u_pick (
        .req  (req_valid),
        .last (last_grant),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    // Accept is combinational and only in IDLE; gated by rst_n so a held
    // reset never shows a grant.
    assign req_ready = (rst_n && state == IDLE && pick_any)
                     ? (NREQ'(1) << pick_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= IDW'(NREQ - 1);
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_y      <= '0;
            rsp_flags  <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        alu_a  <= req_a[int'(pick_idx)*DW +: DW];
                        alu_b  <= req_b[int'(pick_idx)*DW +: DW];
                        alu_op <= req_op[int'(pick_idx)*2 +: 2];
                        rsp_id <= pick_idx;
                        cnt    <= 4'(SETTLE - 1);
                        busy   <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        rsp_y     <= alu_y;
                        rsp_flags <= alu_flags;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    // Pointer moves only once the response is consumed.
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        last_grant <= rsp_id;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
